dcache_wb_dm: RTL and testbench

//  L1 data cache directly downstream of the pipelined datapath MEM stage. Serves dmemREN/dmemWEN/dmemaddr/dmemstore.

---
 rtl/dcache_wb_dm_if.sv | 58 +++++
 rtl/dcache_wb_dm.sv | 249 ++++++++++++++++++++++++
 tb/tb_dcache_wb_dm.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_dm_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_dp_if / dcache_mem_if
//  Description : Bus bundles for the write-back data cache.
//                dcache_dp_if  - datapath MEM stage <-> cache
//                  halt, dmemREN, dmemWEN, dmemaddr, dmemstore  (datapath -> cache)
//                  dhit, dmemload, flushed                      (cache -> datapath)
//                dcache_mem_if - cache <-> memory arbiter
//                  dREN, dWEN, daddr, dstore                    (cache -> memory)
//                  dwait, dload                                 (memory -> cache)
//  Revision    : 1.0  initial release
// ============================================================================

interface dcache_dp_if;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;

    // Datapath side drives requests
    modport master (
        output halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload, flushed
    );

    // Cache side answers them
    modport slave (
        input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload, flushed
    );
endinterface

interface dcache_mem_if;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    // Cache side issues memory transfers
    modport master (
        output dREN, dWEN, daddr, dstore,
        input  dwait, dload
    );

    // Memory arbiter side
    modport slave (
        input  dREN, dWEN, daddr, dstore,
        output dwait, dload
    );
endinterface

`default_nettype wire

// File: rtl/dcache_wb_dm.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_wb_dm
//  Description : Direct-mapped, write-back, write-allocate L1 data cache with
//                2-word blocks. Hits answer combinationally; misses write back
//                a dirty victim and fetch the new block over the memory bus.
//                On halt every dirty block is written back, the hit counter
//                is stored at HITCNT_ADR and flushed is raised (sticky).
//  Ports       : CLK   - clock, all state on posedge
//                nRST  - synchronous active-low reset
//                dp    - datapath bundle (slave modport)
//                mem   - memory arbiter bundle (master modport)
//  Revision    : 1.0  initial release
// ============================================================================

module dcache_wb_dm #(
    parameter int unsigned SETS       = 16,
    parameter logic [31:0] HITCNT_ADR = 32'h0000_3100
) (
    input  logic         CLK,
    input  logic         nRST,
    dcache_dp_if.slave   dp,
    dcache_mem_if.master mem
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - IDX_W - 3;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WB0    = 4'd1,
        S_WB1    = 4'd2,
        S_FETCH0 = 4'd3,
        S_FETCH1 = 4'd4,
        S_FL_CHK = 4'd5,
        S_FL_WB0 = 4'd6,
        S_FL_WB1 = 4'd7,
        S_FL_CNT = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_data [SETS][2];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;
    logic [31:0]      r_hitcnt;
    logic [IDX_W-1:0] r_fidx;
    logic             r_pend;     // next hit is the retry of a fill, not counted

    // ------------------------------------------------------------------
    // Address decomposition and hit detection
    // ------------------------------------------------------------------
    logic             w_req;
    logic             w_wr;
    logic             w_blk;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_fl_wb;
    logic             w_fl_last;
    logic [IDX_W-1:0] w_wb_idx;
    logic [31:0]      w_wb_base;
    logic [31:0]      w_fetch_base;
    logic             w_unused_byte;

    assign w_req   = dp.dmemREN | dp.dmemWEN;
    assign w_wr    = dp.dmemWEN;                // write wins when both are high
    assign w_blk   = dp.dmemaddr[2];
    assign w_idx   = dp.dmemaddr[IDX_W+2:3];
    assign w_tag   = dp.dmemaddr[31:IDX_W+3];
    assign w_hit   = (r_state == S_IDLE) & w_req & r_valid[w_idx]
                   & (r_tag[w_idx] == w_tag);
    assign w_unused_byte = ^dp.dmemaddr[1:0];

    // Write-back source: the flush walker during flush, the request index otherwise
    assign w_fl_wb      = (r_state == S_FL_WB0) || (r_state == S_FL_WB1);
    assign w_wb_idx     = w_fl_wb ? r_fidx : w_idx;
    assign w_wb_base    = {r_tag[w_wb_idx], w_wb_idx, 3'b000};
    assign w_fetch_base = {w_tag, w_idx, 3'b000};
    assign w_fl_last    = (r_fidx == IDX_W'(SETS - 1));

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    logic        w_dren;
    logic        w_dwen;
    logic [31:0] w_daddr;
    logic [31:0] w_dstore;

    always_comb begin
        w_state_nxt = r_state;
        w_dren      = 1'b0;
        w_dwen      = 1'b0;
        w_daddr     = 32'd0;
        w_dstore    = 32'd0;
        case (r_state)
            S_IDLE: begin
                // A hit is served first; halt beats a fresh miss
                if (!w_hit) begin
                    if (dp.halt) begin
                        w_state_nxt = S_FL_CHK;
                    end else if (w_req) begin
                        w_state_nxt = (r_valid[w_idx] & r_dirty[w_idx]) ? S_WB0 : S_FETCH0;
                    end
                end
            end
            S_WB0, S_FL_WB0: begin
                w_dwen   = 1'b1;
                w_daddr  = w_wb_base;
                w_dstore = r_data[w_wb_idx][0];
                if (!mem.dwait) begin
                    w_state_nxt = (r_state == S_WB0) ? S_WB1 : S_FL_WB1;
                end
            end
            S_WB1: begin
                w_dwen   = 1'b1;
                w_daddr  = w_wb_base + 32'd4;
                w_dstore = r_data[w_wb_idx][1];
                if (!mem.dwait) begin
                    w_state_nxt = S_FETCH0;
                end
            end
            S_FL_WB1: begin
                w_dwen   = 1'b1;
                w_daddr  = w_wb_base + 32'd4;
                w_dstore = r_data[w_wb_idx][1];
                if (!mem.dwait) begin
                    w_state_nxt = w_fl_last ? S_FL_CNT : S_FL_CHK;
                end
            end
            S_FETCH0: begin
                w_dren  = 1'b1;
                w_daddr = w_fetch_base;
                if (!mem.dwait) begin
                    w_state_nxt = S_FETCH1;
                end
            end
            S_FETCH1: begin
                w_dren  = 1'b1;
                w_daddr = w_fetch_base + 32'd4;
                if (!mem.dwait) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FL_CHK: begin
                if (r_dirty[r_fidx]) begin
                    w_state_nxt = S_FL_WB0;
                end else if (w_fl_last) begin
                    w_state_nxt = S_FL_CNT;
                end
            end
            S_FL_CNT: begin
                w_dwen   = 1'b1;
                w_daddr  = HITCNT_ADR;
                w_dstore = r_hitcnt;
                if (!mem.dwait) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem.dREN   = w_dren;
    assign mem.dWEN   = w_dwen;
    assign mem.daddr  = w_daddr;
    assign mem.dstore = w_dstore;

    assign dp.dhit     = w_hit;
    assign dp.dmemload = (w_hit & dp.dmemREN & ~dp.dmemWEN) ? r_data[w_idx][w_blk] : 32'd0;
    assign dp.flushed  = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Control state (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_valid  <= '0;
            r_dirty  <= '0;
            r_hitcnt <= 32'd0;
            r_fidx   <= '0;
            r_pend   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hit) begin
                if (r_pend) begin
                    r_pend <= 1'b0;
                end else if (r_hitcnt != 32'hFFFF_FFFF) begin
                    r_hitcnt <= r_hitcnt + 32'd1;
                end
                if (w_wr) begin
                    r_dirty[w_idx] <= 1'b1;
                end
            end
            case (r_state)
                S_FETCH1: begin
                    if (!mem.dwait) begin
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_pend         <= 1'b1;
                    end
                end
                S_FL_CHK: begin
                    if (!r_dirty[r_fidx] && !w_fl_last) begin
                        r_fidx <= r_fidx + 1'b1;
                    end
                end
                S_FL_WB1: begin
                    if (!mem.dwait) begin
                        r_dirty[r_fidx] <= 1'b0;
                        if (!w_fl_last) begin
                            r_fidx <= r_fidx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag and data storage (no reset; qualified by the valid bits)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_hit && w_wr) begin
            r_data[w_idx][w_blk] <= dp.dmemstore;
        end
        if (r_state == S_FETCH0 && !mem.dwait) begin
            r_data[w_idx][0] <= mem.dload;
        end
        if (r_state == S_FETCH1 && !mem.dwait) begin
            r_data[w_idx][1] <= mem.dload;
            r_tag[w_idx]     <= w_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_wb_dm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_wb_dm
//  Description : Self-checking bench for dcache_wb_dm. A behavioural cache
//                model (arrays of valid/dirty/tag/data plus a reference
//                memory) predicts hit/miss, memory traffic, load data and the
//                final flush image; a randomly stalling memory responder
//                records every completed transfer.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps

module tb_dcache_wb_dm;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    dcache_dp_if  dp ();
    dcache_mem_if mem ();

    dcache_wb_dm #(
        .SETS       (16),
        .HITCNT_ADR (32'h0000_3100)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .dp   (dp),
        .mem  (mem)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       log_q [$];
    xfer_t       exp_q [$];
    logic [31:0] env_mem [logic [31:0]];
    int          wcnt       = 2;
    int          wait_fixed = 2;
    int          budget     = -1;   // transfers still allowed; -1 = unlimited

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    always @(negedge CLK) begin
        logic [31:0] d;
        if (mem.dREN || mem.dWEN) begin
            if (budget == 0 || wcnt > 0) begin
                mem.dwait = 1'b1;
                mem.dload = 32'hBAD0_0000;
                if (budget != 0) wcnt--;
            end else begin
                mem.dwait = 1'b0;
                if (mem.dWEN) begin
                    env_mem[mem.daddr] = mem.dstore;
                    log_q.push_back({1'b1, mem.daddr, mem.dstore});
                end else begin
                    d = env_mem.exists(mem.daddr) ? env_mem[mem.daddr] : init_word(mem.daddr);
                    mem.dload = d;
                    log_q.push_back({1'b0, mem.daddr, d});
                end
                wcnt = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 2));
                if (budget > 0) budget--;
            end
        end else begin
            mem.dwait = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [logic [31:0]];
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [24:0] m_tag   [16];
    logic [31:0] m_data  [16][2];
    int unsigned m_hits;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_hits = 0;
    endtask

    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                output bit hit, output logic [31:0] ld);
        logic [3:0]  idx;
        logic [24:0] t;
        logic [31:0] base;
        int          b;
        idx = addr[6:3];
        t   = addr[31:7];
        b   = int'(addr[2]);
        hit = m_valid[idx] && (m_tag[idx] == t);
        if (hit) begin
            m_hits++;
        end else begin
            if (m_valid[idx] && m_dirty[idx]) begin
                base = {m_tag[idx], idx, 3'b000};
                for (int w = 0; w < 2; w++) begin
                    ref_mem[base + 32'(4 * w)] = m_data[idx][w];
                    exp_q.push_back({1'b1, base + 32'(4 * w), m_data[idx][w]});
                end
            end
            base = {t, idx, 3'b000};
            for (int w = 0; w < 2; w++) begin
                m_data[idx][w] = ref_rd(base + 32'(4 * w));
                exp_q.push_back({1'b0, base + 32'(4 * w), m_data[idx][w]});
            end
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_tag[idx]   = t;
        end
        ld = m_data[idx][b];
        if (wr) begin
            m_data[idx][b] = wd;
            m_dirty[idx]   = 1;
        end
    endtask

    task automatic compare_log(input string tag);
        int n;
        check_eq({tag, ".ntx"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s.we%0d", tag, i),   log_q[i].we,   exp_q[i].we);
            check_eq($sformatf("%s.addr%0d", tag, i), log_q[i].addr, exp_q[i].addr);
            check_eq($sformatf("%s.data%0d", tag, i), log_q[i].data, exp_q[i].data);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    // Issue one request (called just after a posedge) and wait for its dhit
    task automatic do_req(input bit ren, input bit wen, input logic [31:0] addr,
                          input logic [31:0] wd, input bit halt_at_fetch);
        bit          exp_hit;
        logic [31:0] exp_ld;
        int          lat;
        bit          got;
        model_access(wen, addr, wd, exp_hit, exp_ld);
        dp.dmemREN   = ren;
        dp.dmemWEN   = wen;
        dp.dmemaddr  = addr;
        dp.dmemstore = wd;
        lat = 0;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (dp.dhit) begin
                got = 1;
                break;
            end
            if (halt_at_fetch && mem.dREN) dp.halt = 1'b1;
            lat++;
        end
        check_eq($sformatf("dhit_seen@%h", addr), 32'(got), 32'd1);
        check_eq($sformatf("first_cycle_hit@%h", addr), 32'(lat == 0), 32'(exp_hit));
        if (got && ren && !wen) check_eq($sformatf("dmemload@%h", addr), dp.dmemload, exp_ld);
        compare_log($sformatf("tx@%h", addr));
        @(posedge CLK);
        #1;
        dp.dmemREN = 1'b0;
        dp.dmemWEN = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, ".dhit"},     32'(dp.dhit),    32'd0);
        check_eq({tag, ".dmemload"}, dp.dmemload,     32'd0);
        check_eq({tag, ".flushed"},  32'(dp.flushed), 32'd0);
        check_eq({tag, ".dREN"},     32'(mem.dREN),   32'd0);
        check_eq({tag, ".dWEN"},     32'(mem.dWEN),   32'd0);
        check_eq({tag, ".daddr"},    mem.daddr,       32'd0);
        check_eq({tag, ".dstore"},   mem.dstore,      32'd0);
    endtask

    task automatic random_reqs(input int n);
        logic [31:0] a;
        int          k;
        for (int i = 0; i < n; i++) begin
            a      = 32'd0;
            a[8:7] = 2'($urandom_range(0, 3));
            a[6:3] = 4'($urandom_range(0, 15));
            a[2]   = 1'($urandom_range(0, 1));
            a[1:0] = 2'($urandom_range(0, 3));
            k = int'($urandom_range(0, 9));
            if (k < 5)      do_req(1'b1, 1'b0, a, $urandom, 1'b0);
            else if (k < 9) do_req(1'b0, 1'b1, a, $urandom, 1'b0);
            else            do_req(1'b1, 1'b1, a, $urandom, 1'b0);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] a_addr;
        logic [31:0] b_addr;
        bit          seen;
        dp.halt      = 1'b0;
        dp.dmemREN   = 1'b0;
        dp.dmemWEN   = 1'b0;
        dp.dmemaddr  = 32'd0;
        dp.dmemstore = 32'd0;
        env_mem[32'h40] = 32'hAAAA_0001;
        env_mem[32'h44] = 32'hAAAA_0002;
        ref_mem[32'h40] = 32'hAAAA_0001;
        ref_mem[32'h44] = 32'hAAAA_0002;
        model_reset();

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_outputs_zero("reset");
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Cold miss with two-cycle memory stalls, then hit on the other word
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b0);
        do_req(1'b1, 1'b0, 32'h0000_0044, 32'd0, 1'b0);
        // Dirty the block, then evict it with a conflicting read
        do_req(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b1, 1'b0, 32'h0000_00C0, 32'd0, 1'b0);

        wait_fixed = -1;
        random_reqs(150);

        // REN and WEN together behave as a write
        do_req(1'b1, 1'b0, 32'h0000_0200, 32'd0, 1'b0);
        do_req(1'b1, 1'b1, 32'h0000_0204, 32'h0BAD_F00D, 1'b0);
        do_req(1'b1, 1'b0, 32'h0000_0204, 32'd0, 1'b0);

        // Reset while the second write-back word is stalled
        a_addr = {25'd6, 4'd3, 3'b000};
        b_addr = {25'd7, 4'd3, 3'b000};
        do_req(1'b0, 1'b1, a_addr, 32'h1234_5678, 1'b0);
        budget      = 1;
        dp.dmemREN  = 1'b1;
        dp.dmemaddr = b_addr;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (mem.dWEN && mem.daddr == a_addr + 32'd4) begin
                seen = 1;
                break;
            end
        end
        check_eq("wb1_reached", 32'(seen), 32'd1);
        @(negedge CLK);
        check_eq("wb1_stalled", 32'(mem.dWEN), 32'd1);
        @(posedge CLK);
        #1;
        nRST       = 1'b0;
        dp.dmemREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_outputs_zero("midwb_reset");
        ref_mem[a_addr] = m_data[3][0];
        exp_q.push_back({1'b1, a_addr, m_data[3][0]});
        compare_log("midwb_reset.tx");
        model_reset();
        @(posedge CLK);
        #1;
        budget = -1;
        wcnt   = 0;
        nRST   = 1'b1;
        do_req(1'b1, 1'b0, b_addr, 32'd0, 1'b0);
        do_req(1'b1, 1'b0, a_addr, 32'd0, 1'b0);

        random_reqs(60);

        // Halt raised while a fill is in progress, then flush
        do_req(1'b1, 1'b0, {25'd5, 4'd9, 3'b100}, 32'd0, 1'b1);
        check_eq("halt_raised", 32'(dp.halt), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                exp_q.push_back({1'b1, {m_tag[i], 4'(i), 3'b000}, m_data[i][0]});
                exp_q.push_back({1'b1, {m_tag[i], 4'(i), 3'b100}, m_data[i][1]});
            end
        end
        exp_q.push_back({1'b1, 32'h0000_3100, 32'(m_hits)});
        seen = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (dp.flushed) begin
                seen = 1;
                break;
            end
        end
        check_eq("flushed_seen", 32'(seen), 32'd1);
        compare_log("flush");

        // Requests after the flush are ignored and flushed stays high
        @(posedge CLK);
        #1;
        dp.halt     = 1'b0;
        dp.dmemREN  = 1'b1;
        dp.dmemaddr = {25'd5, 4'd9, 3'b100};
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check_eq("done.flushed", 32'(dp.flushed), 32'd1);
            check_eq("done.dhit",    32'(dp.dhit),    32'd0);
            check_eq("done.dREN",    32'(mem.dREN),   32'd0);
            check_eq("done.dWEN",    32'(mem.dWEN),   32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
